lector_teclado: RTL

//  Scans a 4x4 matrix keypad, debounces it, and reports each accepted press as a 4-bit key code with a 1-cycle strobe.

---
 rtl/lector_teclado_if.sv | 30 +++
 rtl/lector_teclado.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lector_teclado_if.sv
// ============================================================================
// lector_teclado_if: keypad matrix lines plus key/entry-register outputs.
// Rev 1.0
// ============================================================================
`default_nettype none

interface lector_teclado_if;
  logic [3:0] filas;
  logic [3:0] columnas;
  logic [3:0] tecla;
  logic       tecla_valida;
  logic [3:0] unidades;
  logic [3:0] decenas;
  logic [3:0] centenas;
  logic [3:0] unidadesMillar;

  modport master (
    output filas, tecla, tecla_valida,
    output unidades, decenas, centenas, unidadesMillar,
    input  columnas
  );

  modport slave (
    input  filas, tecla, tecla_valida,
    input  unidades, decenas, centenas, unidadesMillar,
    output columnas
  );
endinterface

`default_nettype wire

// File: rtl/lector_teclado.sv
// ============================================================================
// lector_teclado: 4x4 keypad scanner with frame debouncer and 4-digit entry.
// Rev 1.0
// ============================================================================
`default_nettype none

module lector_teclado #(
  parameter int SCAN_TICKS     = 10000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input wire               clk,
  input wire               rst,
  lector_teclado_if.master bus
);

  localparam int c_TICK_W = $clog2(SCAN_TICKS);
  localparam int c_CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(SCAN_TICKS - 1);
  localparam logic [c_CNT_W-1:0]  c_CNT_PRE   = c_CNT_W'(DEBOUNCE_SCANS - 1);
  localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_CANDIDATO  = 2'd1,
    S_PRESIONADA = 2'd2
  } state_t;

  logic [3:0]          r_col_s1;
  logic [3:0]          r_col_s2;
  logic [c_TICK_W-1:0] r_tick;
  logic [1:0]          r_row;
  logic [3:0]          r_filas;
  logic [1:0]          r_nkeys;
  logic [3:0]          r_acc_code;
  state_t              r_state;
  logic [3:0]          r_cand;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [3:0]          r_tecla;
  logic                r_valida;
  logic [3:0]          r_unidades;
  logic [3:0]          r_decenas;
  logic [3:0]          r_centenas;
  logic [3:0]          r_millar;

  logic                w_sample;
  logic                w_frame_end;
  logic [3:0]          w_low;
  logic [2:0]          w_row_n;
  logic [1:0]          w_col;
  logic [3:0]          w_row_code;
  logic [2:0]          w_tot;
  logic                w_frame_key;
  logic [3:0]          w_frame_code;
  state_t              w_state_nxt;
  logic [3:0]          w_cand_nxt;
  logic [c_CNT_W-1:0]  w_cnt_nxt;
  logic                w_accept;

  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    case ({row, col})
      4'd0:    key_code = 4'h1;
      4'd1:    key_code = 4'h2;
      4'd2:    key_code = 4'h3;
      4'd3:    key_code = 4'hA;
      4'd4:    key_code = 4'h4;
      4'd5:    key_code = 4'h5;
      4'd6:    key_code = 4'h6;
      4'd7:    key_code = 4'hB;
      4'd8:    key_code = 4'h7;
      4'd9:    key_code = 4'h8;
      4'd10:   key_code = 4'h9;
      4'd11:   key_code = 4'hC;
      4'd12:   key_code = 4'hE;
      4'd13:   key_code = 4'h0;
      4'd14:   key_code = 4'hF;
      default: key_code = 4'hD;
    endcase
  endfunction

  assign w_sample    = (r_tick == c_TICK_LAST);
  assign w_frame_end = w_sample && (r_row == 2'd3);

  // Lowest low column wins the code; the count catches multi-key rows.
  always_comb begin
    w_low   = ~r_col_s2;
    w_row_n = 3'd0;
    w_col   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      w_row_n = w_row_n + {2'b00, w_low[i]};
      if (w_low[i]) w_col = 2'(i);
    end
  end

  assign w_row_code   = key_code(r_row, w_col);
  assign w_tot        = {1'b0, r_nkeys} + w_row_n;
  assign w_frame_key  = (w_tot == 3'd1);
  assign w_frame_code = (w_row_n == 3'd1) ? w_row_code : r_acc_code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col_s1   <= 4'hF;
      r_col_s2   <= 4'hF;
      r_tick     <= '0;
      r_row      <= 2'd0;
      r_filas    <= 4'b1110;
      r_nkeys    <= 2'd0;
      r_acc_code <= 4'h0;
    end else begin
      r_col_s1 <= bus.columnas;
      r_col_s2 <= r_col_s1;
      if (w_sample) begin
        r_tick  <= '0;
        r_row   <= r_row + 2'd1;
        r_filas <= {r_filas[2:0], r_filas[3]};
        if (w_frame_end) begin
          r_nkeys    <= 2'd0;
          r_acc_code <= 4'h0;
        end else begin
          r_nkeys <= (w_tot >= 3'd2) ? 2'd2 : w_tot[1:0];
          if (w_row_n == 3'd1) r_acc_code <= w_row_code;
        end
      end else begin
        r_tick <= r_tick + c_TICK_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    if (w_frame_end) begin
      case (r_state)
        S_IDLE: begin
          if (w_frame_key) begin
            w_cand_nxt = w_frame_code;
            if (DEBOUNCE_SCANS == 1) begin
              w_accept    = 1'b1;
              w_state_nxt = S_PRESIONADA;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = S_CANDIDATO;
              w_cnt_nxt   = c_CNT_ONE;
            end
          end
        end
        S_CANDIDATO: begin
          if (!w_frame_key) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else if (w_frame_code == r_cand) begin
            if (r_cnt >= c_CNT_PRE) begin
              w_accept    = 1'b1;
              w_state_nxt = S_PRESIONADA;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + c_CNT_ONE;
            end
          end else begin
            w_cand_nxt = w_frame_code;
            w_cnt_nxt  = c_CNT_ONE;
          end
        end
        S_PRESIONADA: begin
          if (w_frame_key) begin
            w_cnt_nxt = '0;
          end else if (r_cnt >= c_CNT_PRE) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + c_CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cand  <= 4'h0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cand  <= w_cand_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Every accept path carries a code equal to the current frame's single key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tecla    <= 4'h0;
      r_valida   <= 1'b0;
      r_unidades <= 4'h0;
      r_decenas  <= 4'h0;
      r_centenas <= 4'h0;
      r_millar   <= 4'h0;
    end else begin
      r_valida <= w_accept;
      if (w_accept) begin
        r_tecla <= w_frame_code;
        if (w_frame_code <= 4'h9) begin
          r_millar   <= r_centenas;
          r_centenas <= r_decenas;
          r_decenas  <= r_unidades;
          r_unidades <= w_frame_code;
        end else if (w_frame_code == 4'hC) begin
          r_millar   <= 4'h0;
          r_centenas <= 4'h0;
          r_decenas  <= 4'h0;
          r_unidades <= 4'h0;
        end
      end
    end
  end

  assign bus.filas          = r_filas;
  assign bus.tecla          = r_tecla;
  assign bus.tecla_valida   = r_valida;
  assign bus.unidades       = r_unidades;
  assign bus.decenas        = r_decenas;
  assign bus.centenas       = r_centenas;
  assign bus.unidadesMillar = r_millar;

endmodule

`default_nettype wire
